eth_tx_frame_arb: RTL and testbench

//  Frame-aware N-channel AXI-Stream transmit arbiter in front of the 1G MAC TX FIFO (logic_clk domain).

---
 rtl/eth_tx_frame_arb.sv | 220 ++++++++++++++++++++++
 tb/tb_eth_tx_frame_arb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_arb.sv
// Frame-aware round-robin AXI-Stream transmit arbiter in front of the MAC TX FIFO.
// Whole frames are granted per channel. Short frames are zero-padded up to MIN_FRAME_LENGTH.
// Frames longer than MAX_FRAME_LENGTH are cut, flagged bad, and their remainder is discarded.
//
// state | meaning
// IDLE  | no frame in flight; picks the next requesting channel
// PASS  | granted channel muxed straight through to the MAC
// PAD   | source frame ended short; emitting zero bytes up to minimum length
// DROP  | frame truncated at max length; swallowing source bytes until tlast
module eth_tx_frame_arb #(
    parameter int CHANNELS         = 2,
    parameter int MIN_FRAME_LENGTH = 60,
    parameter int MAX_FRAME_LENGTH = 1514,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [8*CHANNELS-1:0]         s_axis_tdata,
    input  logic [CHANNELS-1:0]           s_axis_tvalid,
    output logic [CHANNELS-1:0]           s_axis_tready,
    input  logic [CHANNELS-1:0]           s_axis_tlast,
    input  logic [CHANNELS-1:0]           s_axis_tuser,
    output logic [7:0]                    m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic [2:0]                    grant_ch,
    output logic                          busy,
    output logic [CNT_WIDTH*CHANNELS-1:0] stat_frames,
    output logic [CNT_WIDTH-1:0]          stat_padded,
    output logic [CNT_WIDTH-1:0]          stat_truncated,
    input  logic                          clr_stats
);

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_PAD, ST_DROP} state_t;

    localparam logic [11:0] MIN_LEN = 12'(MIN_FRAME_LENGTH);
    localparam logic [11:0] MAX_LEN = 12'(MAX_FRAME_LENGTH);
    localparam logic [2:0]  LAST_CH = 3'(CHANNELS - 1);

    state_t               r_state, w_state_nxt;
    logic [2:0]           r_grant, r_last_grant, w_grant_nxt;
    logic                 w_grant_found;
    logic [10:0]          r_len;
    logic                 r_err;
    logic [11:0]          w_len_inc;
    logic [7:0]           w_src_data;
    logic                 w_src_valid, w_src_last, w_src_user, w_src_xfer;
    logic                 w_frame_inc, w_pad_inc, w_trunc_inc;
    logic [CNT_WIDTH-1:0] r_frames [CHANNELS];
    logic [CNT_WIDTH-1:0] r_padded, r_trunc;

    assign w_len_inc  = {1'b0, r_len} + 12'd1;
    assign w_src_xfer = w_src_valid & m_axis_tready;
    assign busy       = (r_state != ST_IDLE);
    assign grant_ch   = r_grant;

    // Select the granted channel's stream
    always_comb begin
        w_src_data  = 8'h00;
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        w_src_user  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_grant == 3'(i)) begin
                w_src_data  = s_axis_tdata[8*i +: 8];
                w_src_valid = s_axis_tvalid[i];
                w_src_last  = s_axis_tlast[i];
                w_src_user  = s_axis_tuser[i];
            end
        end
    end

    // Round-robin search: first requester above last_grant, else lowest at or below it
    always_comb begin
        w_grant_nxt   = r_last_grant;
        w_grant_found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_grant_found && s_axis_tvalid[i] && (3'(i) > r_last_grant)) begin
                w_grant_nxt   = 3'(i);
                w_grant_found = 1'b1;
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_grant_found && s_axis_tvalid[i] && (3'(i) <= r_last_grant)) begin
                w_grant_nxt   = 3'(i);
                w_grant_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state, stream outputs and counter increment strobes
    always_comb begin
        w_state_nxt   = r_state;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        w_frame_inc   = 1'b0;
        w_pad_inc     = 1'b0;
        w_trunc_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|s_axis_tvalid) w_state_nxt = ST_PASS;
            end
            ST_PASS: begin
                m_axis_tdata  = w_src_data;
                m_axis_tvalid = w_src_valid;
                m_axis_tuser  = w_src_user;
                for (int i = 0; i < CHANNELS; i++)
                    s_axis_tready[i] = (r_grant == 3'(i)) & m_axis_tready;
                // tlast outranks truncation, so an exactly-MAX frame completes normally.
                // With MIN_LEN = 0 the length test is always true, disabling padding.
                if (w_src_last) begin
                    if (w_len_inc >= MIN_LEN) begin
                        m_axis_tlast = 1'b1;
                        m_axis_tuser = r_err | w_src_user;
                        if (w_src_xfer) begin
                            w_state_nxt = ST_IDLE;
                            w_frame_inc = 1'b1;
                        end
                    end else if (w_src_xfer) begin
                        w_state_nxt = ST_PAD;
                    end
                end else if (w_len_inc == MAX_LEN) begin
                    m_axis_tlast = 1'b1;
                    m_axis_tuser = 1'b1;
                    if (w_src_xfer) begin
                        w_state_nxt = ST_DROP;
                        w_trunc_inc = 1'b1;
                        w_frame_inc = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                m_axis_tvalid = 1'b1;
                if (w_len_inc >= MIN_LEN) begin
                    m_axis_tlast = 1'b1;
                    m_axis_tuser = r_err;
                    if (m_axis_tready) begin
                        w_state_nxt = ST_IDLE;
                        w_pad_inc   = 1'b1;
                        w_frame_inc = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                for (int i = 0; i < CHANNELS; i++)
                    s_axis_tready[i] = (r_grant == 3'(i));
                if (w_src_valid && w_src_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant, output length and accumulated bad-frame flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= 3'd0;
            r_last_grant <= LAST_CH;
            r_len        <= 11'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|s_axis_tvalid) begin
                        r_grant      <= w_grant_nxt;
                        r_last_grant <= w_grant_nxt;
                        r_len        <= 11'd0;
                        r_err        <= 1'b0;
                    end
                end
                ST_PASS: begin
                    if (w_src_xfer) begin
                        r_len <= r_len + 11'd1;
                        r_err <= r_err | w_src_user;
                    end
                end
                ST_PAD: begin
                    if (m_axis_tready) r_len <= r_len + 11'd1;
                end
                default: ;
            endcase
        end
    end

    // Saturating statistics; a clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) r_frames[i] <= '0;
            r_padded <= '0;
            r_trunc  <= '0;
        end else if (clr_stats) begin
            for (int i = 0; i < CHANNELS; i++) r_frames[i] <= '0;
            r_padded <= '0;
            r_trunc  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                if (w_frame_inc && (r_grant == 3'(i)) && (r_frames[i] != '1))
                    r_frames[i] <= r_frames[i] + 1'b1;
            if (w_pad_inc && (r_padded != '1))  r_padded <= r_padded + 1'b1;
            if (w_trunc_inc && (r_trunc != '1)) r_trunc  <= r_trunc + 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_stat
        assign stat_frames[CNT_WIDTH*g +: CNT_WIDTH] = r_frames[g];
    end
    assign stat_padded    = r_padded;
    assign stat_truncated = r_trunc;

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Directed bench for eth_tx_frame_arb with default parameters (2 channels, MIN 60, MAX 1514).
module tb_eth_tx_frame_arb;

    localparam int CH = 2;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    logic [7:0] src_data [CH];
    logic       src_valid [CH];
    logic       src_last [CH];
    logic       src_user [CH];

    logic [8*CH-1:0]  s_axis_tdata;
    logic [CH-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic [2:0]       grant_ch;
    logic             busy;
    logic [CW*CH-1:0] stat_frames;
    logic [CW-1:0]    stat_padded, stat_truncated;
    logic             clr_stats;

    assign s_axis_tdata  = {src_data[1], src_data[0]};
    assign s_axis_tvalid = {src_valid[1], src_valid[0]};
    assign s_axis_tlast  = {src_last[1], src_last[0]};
    assign s_axis_tuser  = {src_user[1], src_user[0]};

    eth_tx_frame_arb #(
        .CHANNELS(CH), .MIN_FRAME_LENGTH(60), .MAX_FRAME_LENGTH(1514), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .grant_ch(grant_ch), .busy(busy),
        .stat_frames(stat_frames), .stat_padded(stat_padded),
        .stat_truncated(stat_truncated), .clr_stats(clr_stats)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [7:0] pat(input bit ch, input int k);
        logic [7:0] v;
        v = 8'(k);
        return v ^ (ch ? 8'hA5 : 8'h3C);
    endfunction

    function automatic int hist_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [31:0] frames_of(input bit ch);
        return ch ? stat_frames[63:32] : stat_frames[31:0];
    endfunction

    // Output monitor: per-frame length/grant/tuser history and byte-pattern mismatches
    int         frame_cnt = 0, beat_cnt = 0, bad_beats = 0, exp_src_len = 0, cur_idx = 0;
    int         len_hist[$], grant_hist[$], user_hist[$];
    logic [7:0] mon_exp;
    always @(posedge clk) begin
        if (!rst_n) begin
            cur_idx = 0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            mon_exp = (cur_idx < exp_src_len) ? pat(grant_ch[0], cur_idx) : 8'h00;
            if (m_axis_tdata !== mon_exp) bad_beats++;
            cur_idx++;
            beat_cnt++;
            if (m_axis_tlast) begin
                len_hist.push_back(cur_idx);
                grant_hist.push_back(int'(grant_ch));
                user_hist.push_back(int'(m_axis_tuser));
                frame_cnt++;
                cur_idx = 0;
            end
        end
    end

    // MAC-side ready: always 1, or coin-flip backpressure
    bit rand_bp = 1'b0;
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    bit abort = 1'b0;

    task automatic send_frame(input bit ch, input int n, input int user_at);
        int guard;
        for (int k = 0; k < n; k++) begin
            if (abort) break;
            src_data[ch]  = pat(ch, k);
            src_valid[ch] = 1'b1;
            src_last[ch]  = (k == n - 1);
            src_user[ch]  = (k + 1 == user_at);
            guard = 0;
            do begin
                @(posedge clk);
                guard++;
            end while (!s_axis_tready[ch] && !abort && guard < 5000);
            if (!s_axis_tready[ch] && !abort) begin
                check_eq("src_stall", 32'(guard), 32'd0);
                break;
            end
            #1;
        end
        src_valid[ch] = 1'b0;
        src_last[ch]  = 1'b0;
        src_user[ch]  = 1'b0;
    endtask

    task automatic wait_frames(input string tag, input int target);
        int guard = 0;
        while (frame_cnt < target && guard < 4000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check_eq(tag, 32'(frame_cnt), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g[4];
        int fc, base, guard;
        exp_g = '{1, 0, 1, 0};
        for (int i = 0; i < CH; i++) begin
            src_data[i] = 8'h00; src_valid[i] = 1'b0; src_last[i] = 1'b0; src_user[i] = 1'b0;
        end
        clr_stats = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tvalid", 32'(m_axis_tvalid), 0);
        check_eq("rst_tready", 32'(s_axis_tready), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_grant", 32'(grant_ch), 0);
        check_eq("rst_frames0", frames_of(0), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single 100-byte frame
        exp_src_len = 100; bad_beats = 0;
        send_frame(0, 100, 0);
        wait_frames("t1_done", 1);
        check_eq("t1_len", 32'(hist_at(len_hist, 0)), 100);
        check_eq("t1_grant", 32'(hist_at(grant_hist, 0)), 0);
        check_eq("t1_tuser", 32'(hist_at(user_hist, 0)), 0);
        check_eq("t1_data", 32'(bad_beats), 0);
        check_eq("t1_frames0", frames_of(0), 1);

        // both channels continuously valid: whole frames alternate starting after last grant
        exp_src_len = 64; bad_beats = 0;
        fork
            begin send_frame(0, 64, 0); send_frame(0, 64, 0); end
            begin send_frame(1, 64, 0); send_frame(1, 64, 0); end
        join
        wait_frames("t2_done", 5);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t2_grant%0d", i), 32'(hist_at(grant_hist, i + 1)), 32'(exp_g[i]));
            check_eq($sformatf("t2_len%0d", i), 32'(hist_at(len_hist, i + 1)), 64);
        end
        check_eq("t2_data", 32'(bad_beats), 0);
        check_eq("t2_frames0", frames_of(0), 3);
        check_eq("t2_frames1", frames_of(1), 2);

        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        check_eq("clr_frames0", frames_of(0), 0);
        check_eq("clr_frames1", frames_of(1), 0);

        // 10-byte runt on ch1 padded to 60
        exp_src_len = 10; bad_beats = 0;
        send_frame(1, 10, 0);
        wait_frames("t3_done", 6);
        check_eq("t3_len", 32'(hist_at(len_hist, 5)), 60);
        check_eq("t3_grant", 32'(hist_at(grant_hist, 5)), 1);
        check_eq("t3_tuser", 32'(hist_at(user_hist, 5)), 0);
        check_eq("t3_data", 32'(bad_beats), 0);
        check_eq("t3_padded", stat_padded, 1);
        check_eq("t3_frames1", frames_of(1), 1);

        // 1600-byte frame truncated at 1514
        exp_src_len = 1600; bad_beats = 0;
        send_frame(0, 1600, 0);
        check_eq("t4_idle_after_drop", 32'(busy), 0);
        wait_frames("t4_done", 7);
        check_eq("t4_len", 32'(hist_at(len_hist, 6)), 1514);
        check_eq("t4_tuser", 32'(hist_at(user_hist, 6)), 1);
        check_eq("t4_data", 32'(bad_beats), 0);
        check_eq("t4_trunc", stat_truncated, 1);
        check_eq("t4_frames0", frames_of(0), 1);

        // backpressure plus bad-byte flag on byte 5 of a 20-byte frame
        rand_bp = 1'b1;
        exp_src_len = 20; bad_beats = 0;
        send_frame(0, 20, 5);
        wait_frames("t5_done", 8);
        rand_bp = 1'b0;
        check_eq("t5_len", 32'(hist_at(len_hist, 7)), 60);
        check_eq("t5_tuser", 32'(hist_at(user_hist, 7)), 1);
        check_eq("t5_data", 32'(bad_beats), 0);
        check_eq("t5_padded", stat_padded, 2);

        // boundary lengths: exactly MIN (no pad) and exactly MAX with tlast (not truncated)
        exp_src_len = 60; bad_beats = 0;
        send_frame(1, 60, 0);
        wait_frames("t7_min_done", 9);
        check_eq("t7_min_len", 32'(hist_at(len_hist, 8)), 60);
        check_eq("t7_min_padded", stat_padded, 2);
        exp_src_len = 1514;
        send_frame(0, 1514, 0);
        wait_frames("t7_max_done", 10);
        check_eq("t7_max_len", 32'(hist_at(len_hist, 9)), 1514);
        check_eq("t7_max_tuser", 32'(hist_at(user_hist, 9)), 0);
        check_eq("t7_max_trunc", stat_truncated, 1);
        check_eq("t7_data", 32'(bad_beats), 0);
        check_eq("t7_frames0", frames_of(0), 3);

        // reset in the middle of a frame
        exp_src_len = 100;
        base = beat_cnt;
        fork send_frame(1, 100, 0); join_none
        guard = 0;
        while (beat_cnt < base + 30 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        #1;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        check_eq("t6_rst_tvalid", 32'(m_axis_tvalid), 0);
        check_eq("t6_rst_tlast", 32'(m_axis_tlast), 0);
        check_eq("t6_rst_busy", 32'(busy), 0);
        check_eq("t6_rst_tready", 32'(s_axis_tready), 0);
        check_eq("t6_rst_frames0", frames_of(0), 0);
        check_eq("t6_rst_padded", stat_padded, 0);
        check_eq("t6_rst_trunc", stat_truncated, 0);
        wait fork;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_src_len = 60; bad_beats = 0;
        fc = frame_cnt;
        fork
            send_frame(0, 60, 0);
            send_frame(1, 60, 0);
        join
        wait_frames("t6_done", fc + 2);
        check_eq("t6_first_grant", 32'(hist_at(grant_hist, fc)), 0);
        check_eq("t6_second_grant", 32'(hist_at(grant_hist, fc + 1)), 1);
        check_eq("t6_len", 32'(hist_at(len_hist, fc)), 60);
        check_eq("t6_data", 32'(bad_beats), 0);
        check_eq("t6_frames0", frames_of(0), 1);
        check_eq("t6_frames1", frames_of(1), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
